// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write-address path: burst encodings,
// page geometry and the packed AW channel layout used by the AW buffer.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // AXI forbids a burst from crossing a 4 KiB boundary.
   localparam int unsigned PAGE_BYTES = 4096;
   localparam int unsigned PAGE_BITS  = 12;

   // Default channel widths for the packed AW record.
   localparam int unsigned AW_ID_WIDTH   = 4;
   localparam int unsigned AW_ADDR_WIDTH = 32;
   localparam int unsigned AW_USER_WIDTH = 1;

   // Fixed-width attributes that ride along with every fragment unchanged.
   typedef struct packed {
      logic [2:0] prot;
      logic [3:0] region;
      logic [2:0] size;
      logic [1:0] burst;
      logic       lock;
      logic [3:0] cache;
      logic [3:0] qos;
   } aw_attr_t;

   // Full AW record; field order matches the AW buffer's s_data_in packing.
   typedef struct packed {
      logic [AW_ID_WIDTH-1:0]   id;
      logic [AW_ADDR_WIDTH-1:0] addr;
      logic [7:0]               len;
      aw_attr_t                 attr;
      logic [AW_USER_WIDTH-1:0] user;
      logic                     last;
   } aw_chan_t;

endpackage

// File: rtl/axi_aw_frag_calc.sv
// Combinational fragment sizing: how many beats fit before the next 4 KiB
// page (capped by MAX_BEATS and the remaining beats) and where the next
// fragment starts.
module axi_aw_frag_calc
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MAX_BEATS  = 256
) (
   input  logic [ADDR_WIDTH-1:0] cur_addr_i,
   input  logic [2:0]            size_i,
   input  logic [8:0]            beats_left_i,
   input  logic                  incr_i,
   output logic [8:0]            frag_o,
   output logic                  last_o,
   output logic [ADDR_WIDTH-1:0] next_addr_o
);

   localparam logic [12:0] MAX_B     = 13'(MAX_BEATS);
   localparam logic [12:0] PAGE_B    = 13'(PAGE_BYTES);

   logic [ADDR_WIDTH-1:0] low_mask;
   logic [ADDR_WIDTH-1:0] aligned;
   logic [12:0]           to_page;
   logic [12:0]           left_w;
   logic [12:0]           frag_w;
   logic [15:0]           step;

   // Size the fragment and advance the address; non-INCR bursts are never split.
   always_comb begin
      low_mask = (ADDR_WIDTH'(1) << size_i) - ADDR_WIDTH'(1);
      aligned  = cur_addr_i & ~low_mask;
      // aligned[11:0] is a multiple of the beat size, so the result is >= 1.
      to_page  = (PAGE_B - {1'b0, aligned[PAGE_BITS-1:0]}) >> size_i;
      left_w   = {4'b0000, beats_left_i};
      frag_w   = left_w;
      if (to_page < frag_w) frag_w = to_page;
      if (MAX_B < frag_w)   frag_w = MAX_B;
      if (!incr_i)          frag_w = left_w;
      frag_o      = frag_w[8:0];
      last_o      = !incr_i || (frag_w == left_w);
      // At most 256 beats of 128 bytes, which fits in 16 bits.
      step        = 16'(frag_o) << size_i;
      next_addr_o = aligned + ADDR_WIDTH'(step);
   end

endmodule

// File: rtl/axi_aw_4k_splitter.sv
// AW-channel splitter: re-issues each INCR burst as page-safe fragments of
// at most MAX_BEATS beats, tagging the final fragment for the B merger.
module axi_aw_4k_splitter
   import axi_pkg::*;
#(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned MAX_BEATS  = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  slave_valid_i,
   input  logic [ADDR_WIDTH-1:0] slave_addr_i,
   input  logic [2:0]            slave_prot_i,
   input  logic [3:0]            slave_region_i,
   input  logic [7:0]            slave_len_i,
   input  logic [2:0]            slave_size_i,
   input  logic [1:0]            slave_burst_i,
   input  logic                  slave_lock_i,
   input  logic [3:0]            slave_cache_i,
   input  logic [3:0]            slave_qos_i,
   input  logic [ID_WIDTH-1:0]   slave_id_i,
   input  logic [USER_WIDTH-1:0] slave_user_i,
   output logic                  slave_ready_o,
   output logic                  master_valid_o,
   output logic [ADDR_WIDTH-1:0] master_addr_o,
   output logic [2:0]            master_prot_o,
   output logic [3:0]            master_region_o,
   output logic [7:0]            master_len_o,
   output logic [2:0]            master_size_o,
   output logic [1:0]            master_burst_o,
   output logic                  master_lock_o,
   output logic [3:0]            master_cache_o,
   output logic [3:0]            master_qos_o,
   output logic [ID_WIDTH-1:0]   master_id_o,
   output logic [USER_WIDTH-1:0] master_user_o,
   output logic                  master_last_o,
   input  logic                  master_ready_i
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [8:0]            beats_left_q, beats_left_d;
   aw_attr_t              attr_q, attr_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [USER_WIDTH-1:0] user_q, user_d;

   logic                  emit;
   logic                  accept;
   logic [8:0]            frag;
   logic                  frag_last;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [8:0]            len_full;

   assign emit = (state_q == ST_EMIT);

   axi_aw_frag_calc #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MAX_BEATS  (MAX_BEATS)
   ) u_frag_calc (
      .cur_addr_i   (addr_q),
      .size_i       (attr_q.size),
      .beats_left_i (beats_left_q),
      .incr_i       (attr_q.burst == BURST_INCR),
      .frag_o       (frag),
      .last_o       (frag_last),
      .next_addr_o  (next_addr)
   );

   // Upstream is open when idle, or in the very cycle the last fragment leaves.
   always_comb begin
      slave_ready_o  = !emit || (master_ready_i && frag_last);
      master_valid_o = emit;
      accept         = slave_valid_i && slave_ready_o;
   end

   // Next-state: capture a new burst, or step to the next fragment on handshake.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beats_left_d = beats_left_q;
      attr_d       = attr_q;
      id_d         = id_q;
      user_d       = user_q;
      if (accept) begin
         state_d       = ST_EMIT;
         addr_d        = slave_addr_i;
         beats_left_d  = {1'b0, slave_len_i} + 9'd1;
         attr_d.prot   = slave_prot_i;
         attr_d.region = slave_region_i;
         attr_d.size   = slave_size_i;
         attr_d.burst  = slave_burst_i;
         attr_d.lock   = slave_lock_i;
         attr_d.cache  = slave_cache_i;
         attr_d.qos    = slave_qos_i;
         id_d          = slave_id_i;
         user_d        = slave_user_i;
      end else if (emit && master_ready_i) begin
         if (frag_last) begin
            state_d = ST_IDLE;
         end else begin
            addr_d       = next_addr;
            beats_left_d = beats_left_q - frag;
         end
      end
   end

   // State and captured burst fields; reset drops any outstanding fragments.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         beats_left_q <= '0;
         attr_q       <= '0;
         id_q         <= '0;
         user_q       <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         beats_left_q <= beats_left_d;
         attr_q       <= attr_d;
         id_q         <= id_d;
         user_q       <= user_d;
      end
   end

   // Fragment fields; len and last are qualified so idle/reset reads zero.
   always_comb begin
      len_full        = frag - 9'd1;
      master_addr_o   = addr_q;
      master_len_o    = emit ? len_full[7:0] : 8'd0;
      master_last_o   = emit && frag_last;
      master_prot_o   = attr_q.prot;
      master_region_o = attr_q.region;
      master_size_o   = attr_q.size;
      master_burst_o  = attr_q.burst;
      master_lock_o   = attr_q.lock;
      master_cache_o  = attr_q.cache;
      master_qos_o    = attr_q.qos;
      master_id_o     = id_q;
      master_user_o   = user_q;
   end

endmodule

// File: tb/tb_axi_aw_4k_splitter.sv
// Scoreboard bench for the AW 4 KiB splitter: directed cases plus random
// bursts checked against a page-arithmetic reference model.
module tb_axi_aw_4k_splitter;

   localparam int MAXB = 64;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        slave_valid_i;
   logic [31:0] slave_addr_i;
   logic [2:0]  slave_prot_i;
   logic [3:0]  slave_region_i;
   logic [7:0]  slave_len_i;
   logic [2:0]  slave_size_i;
   logic [1:0]  slave_burst_i;
   logic        slave_lock_i;
   logic [3:0]  slave_cache_i;
   logic [3:0]  slave_qos_i;
   logic [3:0]  slave_id_i;
   logic [0:0]  slave_user_i;
   logic        slave_ready_o;
   logic        master_valid_o;
   logic [31:0] master_addr_o;
   logic [2:0]  master_prot_o;
   logic [3:0]  master_region_o;
   logic [7:0]  master_len_o;
   logic [2:0]  master_size_o;
   logic [1:0]  master_burst_o;
   logic        master_lock_o;
   logic [3:0]  master_cache_o;
   logic [3:0]  master_qos_o;
   logic [3:0]  master_id_o;
   logic [0:0]  master_user_o;
   logic        master_last_o;
   logic        master_ready_i;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  id;
      logic        user;
      logic [2:0]  prot;
      logic [3:0]  region;
      logic        lock;
      logic [3:0]  cache;
      logic [3:0]  qos;
      logic        last;
   } frag_t;

   frag_t exp_q[$];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    hs_total = 0;
   int    hs_prev  = 0;
   int    hs_last  = 0;
   bit    ready_mode  = 1'b0;
   bit    ready_force = 1'b1;

   always #5 clk = ~clk;

   axi_aw_4k_splitter #(
      .ID_WIDTH   (4),
      .ADDR_WIDTH (32),
      .USER_WIDTH (1),
      .MAX_BEATS  (MAXB)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .slave_valid_i   (slave_valid_i),
      .slave_addr_i    (slave_addr_i),
      .slave_prot_i    (slave_prot_i),
      .slave_region_i  (slave_region_i),
      .slave_len_i     (slave_len_i),
      .slave_size_i    (slave_size_i),
      .slave_burst_i   (slave_burst_i),
      .slave_lock_i    (slave_lock_i),
      .slave_cache_i   (slave_cache_i),
      .slave_qos_i     (slave_qos_i),
      .slave_id_i      (slave_id_i),
      .slave_user_i    (slave_user_i),
      .slave_ready_o   (slave_ready_o),
      .master_valid_o  (master_valid_o),
      .master_addr_o   (master_addr_o),
      .master_prot_o   (master_prot_o),
      .master_region_o (master_region_o),
      .master_len_o    (master_len_o),
      .master_size_o   (master_size_o),
      .master_burst_o  (master_burst_o),
      .master_lock_o   (master_lock_o),
      .master_cache_o  (master_cache_o),
      .master_qos_o    (master_qos_o),
      .master_id_o     (master_id_o),
      .master_user_o   (master_user_o),
      .master_last_o   (master_last_o),
      .master_ready_i  (master_ready_i)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: forced value or random back-pressure.
   initial begin
      master_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         master_ready_i = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   function automatic frag_t sample_out();
      frag_t a;
      a.addr   = master_addr_o;
      a.len    = master_len_o;
      a.size   = master_size_o;
      a.burst  = master_burst_o;
      a.id     = master_id_o;
      a.user   = master_user_o[0];
      a.prot   = master_prot_o;
      a.region = master_region_o;
      a.lock   = master_lock_o;
      a.cache  = master_cache_o;
      a.qos    = master_qos_o;
      a.last   = master_last_o;
      return a;
   endfunction

   // Monitor: pops the scoreboard on every handshake, checks hold stability.
   initial begin
      frag_t act;
      frag_t held;
      frag_t e;
      bit    hold_pending;
      hold_pending = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         act = sample_out();
         if (hold_pending && master_valid_o) begin
            total++;
            if (act !== held) begin
               bad++;
               $display("FAIL hold_stable: got %h want %h", act, held);
            end
         end
         if (master_valid_o && master_ready_i) begin
            hs_prev = hs_last;
            hs_last = cyc;
            hs_total++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL frag_unexpected: got addr=%h len=%0d last=%0d want no fragment",
                        act.addr, act.len, act.last);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  bad++;
                  $display("FAIL frag: got addr=%h len=%0d last=%0d id=%0d all=%h want addr=%h len=%0d last=%0d id=%0d all=%h",
                           act.addr, act.len, act.last, act.id, act, e.addr, e.len, e.last, e.id, e);
               end else begin
                  $display("frag ok addr=%h len=%0d last=%0d id=%0d", act.addr, act.len, act.last, act.id);
               end
            end
         end
         hold_pending = master_valid_o && !master_ready_i;
         held = act;
      end
   end

   function automatic frag_t mk(input logic [31:0] a, input logic [7:0] l,
                                input logic [2:0] s, input logic [1:0] b, input logic [3:0] id);
      frag_t r;
      r.addr = a; r.len = l; r.size = s; r.burst = b; r.id = id;
      r.user = 1'b1; r.prot = 3'b010; r.region = 4'h3; r.lock = 1'b0;
      r.cache = 4'hF; r.qos = 4'h5; r.last = 1'b0;
      return r;
   endfunction

   task automatic exp_push(input frag_t base, input logic [31:0] a, input logic [7:0] l, input logic last);
      frag_t f;
      f = base; f.addr = a; f.len = l; f.last = last;
      exp_q.push_back(f);
   endtask

   // Reference model: walk the byte range page by page with plain arithmetic.
   task automatic model_push(input frag_t r);
      longint unsigned addr;
      longint unsigned aligned;
      longint unsigned bytes;
      longint unsigned to_page;
      longint unsigned rem;
      longint unsigned n;
      frag_t f;
      if (r.burst != 2'b01) begin
         exp_push(r, r.addr, r.len, 1'b1);
      end else begin
         addr  = longint'(r.addr);
         rem   = longint'(r.len) + 1;
         bytes = longint'(1) << r.size;
         while (rem > 0) begin
            aligned = addr - (addr % bytes);
            to_page = (4096 - (aligned % 4096)) / bytes;
            n = rem;
            if (to_page < n) n = to_page;
            if (MAXB < n) n = MAXB;
            f = r;
            f.addr = addr[31:0];
            f.len  = 8'(n - 1);
            f.last = (n == rem);
            exp_q.push_back(f);
            addr = (aligned + n * bytes) % 64'h1_0000_0000;
            rem  = rem - n;
         end
      end
   endtask

   // Present one request; returns one cycle after it was accepted.
   task automatic send(input frag_t r);
      bit ok;
      ok = 1'b0;
      slave_valid_i  = 1'b1;
      slave_addr_i   = r.addr;
      slave_len_i    = r.len;
      slave_size_i   = r.size;
      slave_burst_i  = r.burst;
      slave_id_i     = r.id;
      slave_user_i   = r.user;
      slave_prot_i   = r.prot;
      slave_region_i = r.region;
      slave_lock_i   = r.lock;
      slave_cache_i  = r.cache;
      slave_qos_i    = r.qos;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (slave_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      slave_valid_i = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL accept_timeout: got ready=0 want ready=1 addr=%h", r.addr);
      end else begin
         $display("req addr=%h len=%0d size=%0d burst=%0d id=%0d", r.addr, r.len, r.size, r.burst, r.id);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 20000; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d outstanding want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   initial begin
      frag_t r;
      frag_t r2;
      frag_t z;
      int    p;
      rst_ni = 1'b0;
      slave_valid_i = 1'b0; slave_addr_i = '0; slave_len_i = '0; slave_size_i = '0;
      slave_burst_i = '0; slave_id_i = '0; slave_user_i = '0; slave_prot_i = '0;
      slave_region_i = '0; slave_lock_i = 1'b0; slave_cache_i = '0; slave_qos_i = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_bit("rst_valid", master_valid_o, 1'b0);
      check_bit("rst_slave_ready", slave_ready_o, 1'b1);
      check_bit("rst_last", master_last_o, 1'b0);
      z = sample_out();
      total++;
      if (z !== '0) begin
         bad++;
         $display("FAIL rst_fields: got %h want 0", z);
      end
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // Page crossing: 8 beats x 4 B from 0xFF0
      r = mk(32'h0000_0FF0, 8'd7, 3'd2, 2'b01, 4'd1);
      exp_push(r, 32'h0000_0FF0, 8'd3, 1'b0);
      exp_push(r, 32'h0000_1000, 8'd3, 1'b1);
      send(r);
      wait_drain();

      // MAX_BEATS cap with a 3-cycle back-pressure gap after the first fragment
      r = mk(32'h0000_0000, 8'd255, 3'd3, 2'b01, 4'd2);
      exp_push(r, 32'h0000_0000, 8'd63, 1'b0);
      exp_push(r, 32'h0000_0200, 8'd63, 1'b0);
      exp_push(r, 32'h0000_0400, 8'd63, 1'b0);
      exp_push(r, 32'h0000_0600, 8'd63, 1'b1);
      send(r);
      @(posedge clk);
      #1;
      ready_force = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      ready_force = 1'b1;
      wait_drain();

      // Unaligned start
      r = mk(32'h0000_0FFE, 8'd1, 3'd2, 2'b01, 4'd3);
      exp_push(r, 32'h0000_0FFE, 8'd0, 1'b0);
      exp_push(r, 32'h0000_1000, 8'd0, 1'b1);
      send(r);
      wait_drain();

      // WRAP passes through unchanged
      r = mk(32'h0000_0FF8, 8'd3, 3'd2, 2'b10, 4'd4);
      exp_push(r, 32'h0000_0FF8, 8'd3, 1'b1);
      send(r);
      wait_drain();

      // Burst ending exactly on the page boundary: single fragment
      r = mk(32'h0000_0FC0, 8'd15, 3'd2, 2'b01, 4'd8);
      exp_push(r, 32'h0000_0FC0, 8'd15, 1'b1);
      send(r);
      wait_drain();

      // Address wraps at the top of the address space
      r = mk(32'hFFFF_FFF0, 8'd7, 3'd2, 2'b01, 4'd9);
      exp_push(r, 32'hFFFF_FFF0, 8'd3, 1'b0);
      exp_push(r, 32'h0000_0000, 8'd3, 1'b1);
      send(r);
      wait_drain();

      // Back-to-back single-beat bursts: no bubble between fragments
      r  = mk(32'h0000_0100, 8'd0, 3'd2, 2'b01, 4'd5);
      r2 = mk(32'h0000_0104, 8'd0, 3'd2, 2'b01, 4'd6);
      exp_push(r, 32'h0000_0100, 8'd0, 1'b1);
      exp_push(r2, 32'h0000_0104, 8'd0, 1'b1);
      p = hs_total;
      send(r);
      send(r2);
      wait_drain();
      total++;
      if ((hs_total - p) != 2 || (hs_last - hs_prev) != 1) begin
         bad++;
         $display("FAIL b2b_gap: got handshakes=%0d gap=%0d want handshakes=2 gap=1",
                  hs_total - p, hs_last - hs_prev);
      end

      // Reset with two fragments still pending
      ready_force = 1'b0;
      r = mk(32'h0000_0000, 8'd191, 3'd0, 2'b01, 4'd7);
      exp_push(r, 32'h0000_0000, 8'd63, 1'b0);
      send(r);
      ready_force = 1'b1;
      @(posedge clk);
      #1;
      ready_force = 1'b0;
      @(negedge clk);
      check_bit("pending_valid", master_valid_o, 1'b1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_bit("async_rst_valid", master_valid_o, 1'b0);
      check_bit("async_rst_last", master_last_o, 1'b0);
      check_bit("async_rst_slave_ready", slave_ready_o, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      ready_force = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check_bit("post_rst_valid", master_valid_o, 1'b0);
         check_bit("post_rst_slave_ready", slave_ready_o, 1'b1);
      end
      exp_q.delete();
      @(posedge clk);
      #1;

      // Randomised bursts under random back-pressure
      ready_mode = 1'b1;
      for (int n = 0; n < 80; n++) begin
         r = mk($urandom, 8'd0, 3'd0, 2'b01, 4'($urandom));
         if ($urandom_range(0, 1) == 1) r.addr[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
         r.len    = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
         r.size   = 3'($urandom_range(0, 7));
         p        = int'($urandom_range(0, 9));
         r.burst  = (p < 7) ? 2'b01 : (p == 7) ? 2'b00 : (p == 8) ? 2'b10 : 2'b11;
         r.user   = 1'($urandom);
         r.prot   = 3'($urandom);
         r.region = 4'($urandom);
         r.lock   = 1'($urandom);
         r.cache  = 4'($urandom);
         r.qos    = 4'($urandom);
         model_push(r);
         send(r);
      end
      wait_drain();
      ready_mode = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_aw_4k_splitter.md
Name: axi_aw_4k_splitter

Overview:
- Write-address stage placed directly upstream of the AW FIFO buffer in the iDMA/iNoC write path.
- Accepts AXI4 AW requests from the DMA engine and re-issues each INCR burst as one or more legal fragments.
- Each fragment stays inside one 4 KiB page and is at most MAX_BEATS beats long.
- Tags the final fragment of each original burst so the downstream B-response merger can merge write responses.

Parameters:
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 32, AXI address width (>= 12).
- USER_WIDTH, 1, AXI user width.
- MAX_BEATS, 256, maximum beats per emitted fragment; power of two, 1..256.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- slave_valid_i  in  1  upstream AW valid
- slave_addr_i  in  ADDR_WIDTH  start address
- slave_prot_i  in  3  protection
- slave_region_i  in  4  region
- slave_len_i  in  8  beats-1
- slave_size_i  in  3  log2 bytes/beat
- slave_burst_i  in  2  burst type (00 FIXED, 01 INCR, 10 WRAP)
- slave_lock_i  in  1  lock
- slave_cache_i  in  4  cache
- slave_qos_i  in  4  QoS
- slave_id_i  in  ID_WIDTH  ID
- slave_user_i  in  USER_WIDTH  user
- slave_ready_o  out  1  upstream ready
- master_valid_o  out  1  fragment valid
- master_addr_o, master_prot_o, master_region_o, master_len_o, master_size_o, master_burst_o, master_lock_o, master_cache_o, master_qos_o, master_id_o, master_user_o  out  same widths as the slave_* inputs  fragment fields
- master_last_o  out  1  fragment is the final one of its original burst
- master_ready_i  in  1  downstream ready (AW buffer)

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE; all registered fields cleared.
  - master_valid_o=0, master_last_o=0, slave_ready_o=1.
  - Every master_* field output reads 0.
- States:
  - IDLE: slave_ready_o=1, master_valid_o=0. slave_valid_i&&slave_ready_o captures all fields into registers. beats_left (9 bit) = slave_len_i+1, cur_addr = slave_addr_i. Next state is EMIT.
  - EMIT: master_valid_o=1. Fields are driven from registers and stay stable until the handshake (AXI rule).
- Fragment computation, INCR bursts, combinational from registers:
  - aligned = cur_addr with the low slave_size bits cleared.
  - to_4k = (4096 - aligned[11:0]) >> size, computed in 13-bit arithmetic.
  - frag = min(beats_left, to_4k, MAX_BEATS).
  - master_addr_o = cur_addr, unaligned only on the first fragment.
  - master_len_o = frag-1. master_last_o = (frag==beats_left).
- FIXED/WRAP bursts are passed through as a single fragment with master_last_o=1; no splitting. Bursts with burst=11 are treated as FIXED.
- On EMIT handshake, not last: cur_addr = aligned + (frag<<size); beats_left -= frag; stay in EMIT.
- On EMIT handshake, last:
  - slave_ready_o=1 in the same cycle (combinational from master_ready_i && last).
  - If slave_valid_i is also high, the new burst is captured and the state stays EMIT (back-to-back, no bubble). Otherwise the state goes to IDLE.
  - slave_ready_o=0 in all other EMIT cycles.
- Latency: first fragment valid 1 cycle after acceptance. Fragments are issued one per cycle while master_ready_i=1.
- master_ready_i low: hold every output; no field may change while master_valid_o=1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Page crossings above bit 11 come from normal carry.
- A burst ending exactly on a 4 KiB boundary produces no empty trailing fragment.
- Reset asserted mid-burst: all fragments still outstanding are dropped, with no further output after reset deasserts.

Decomposition:
- Shared package axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - constant PAGE_BYTES=4096;
  - a packed AW-channel struct typedef reused by the AW buffer's s_data_in packing order.
- One natural sub-module, axi_aw_frag_calc: purely combinational; computes frag and next address from cur_addr, size, beats_left and MAX_BEATS.

Test Plan:
- INCR addr=0x0000_0FF0, len=7, size=2 (8 beats x 4 B) -> two fragments:
  - fragment 1: addr 0x0FF0, len 3, last=0;
  - fragment 2: addr 0x1000, len 3, last=1.
- INCR addr=0x0000_0000, len=255, size=3, MAX_BEATS=64 -> four fragments:
  - addresses 0x000/0x200/0x400/0x600;
  - len 63 each; last only on the fourth.
- Unaligned INCR addr=0x0FFE, len=1, size=2 -> fragment 1 addr 0x0FFE len 0; fragment 2 addr 0x1000 len 0, last=1.
- WRAP addr=0x0FF8, len=3, size=2 -> single fragment passed through unchanged, last=1.
- Back-to-back: two INCR len=0 requests presented continuously with master_ready_i=1 -> after the first fragment, one fragment per cycle with no bubble. master_ready_i low 3 cycles mid-burst -> outputs held stable.
- Assert rst_ni low while EMIT holds 2 fragments pending -> master_valid_o=0 immediately; slave_ready_o=1 after release.
